// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - loadable synchronous-read instruction memory
//
// Instruction store for the RV32I core. After reset the memory sits in
// LOADING and accepts an image one word at a time from a boot loader; once
// the last word arrives it enters RUN and serves fetches with one cycle of
// read latency. A fetch to a misaligned or out-of-range address returns
// NOP_WORD with FetchFault_o set.
//
// Ports:
//   Clk_i            system clock, rising edge
//   Reset_i          synchronous active-high reset
//   LoadStart_i      in RUN: restart loading at word 0
//   LoadValid_i      LoadData_i valid this cycle
//   LoadData_i       instruction word to write at the load pointer
//   LoadLast_i       final word of the image (qualified by LoadValid_i)
//   LoadReady_o      high in LOADING
//   Loaded_o         high in RUN
//   FetchReq_i       fetch request
//   Address_i        byte address of the instruction
//   FetchStall_o     request cannot be accepted (still loading)
//   InstructionOut_o fetched word, valid with FetchValid_o
//   FetchValid_o     response to the request accepted last cycle
//   FetchFault_o     misaligned or out-of-range fetch (with FetchValid_o)

module instr_mem_loadable #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  LoadStart_i,
    input  logic                  LoadValid_i,
    input  logic [31:0]           LoadData_i,
    input  logic                  LoadLast_i,
    output logic                  LoadReady_o,
    output logic                  Loaded_o,
    input  logic                  FetchReq_i,
    input  logic [ADDR_WIDTH-1:0] Address_i,
    output logic                  FetchStall_o,
    output logic [31:0]           InstructionOut_o,
    output logic                  FetchValid_o,
    output logic                  FetchFault_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {
        ST_LOADING = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;

    logic                  load_accept;
    logic                  fetch_accept;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fetch_fault;

    assign load_accept  = LoadValid_i && (state_q == ST_LOADING);
    assign fetch_accept = FetchReq_i && (state_q == ST_RUN);

    // Full-width compare so any set upper address bit counts as out of range.
    assign word_addr    = Address_i >> 2;
    assign misaligned   = (Address_i[1:0] != 2'b00);
    assign out_of_range = (word_addr >= ADDR_WIDTH'(DEPTH_WORDS));
    assign fetch_fault  = misaligned || out_of_range;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_LOADING: begin
                if (load_accept) begin
                    // The final slot ends the image even without LoadLast,
                    // so the pointer never wraps back over word 0.
                    if (LoadLast_i || (ptr_q == LAST_IDX)) begin
                        state_d = ST_RUN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (LoadStart_i) begin
                    state_d = ST_LOADING;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOADING;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = fetch_accept;
        fault_d = fetch_accept && fetch_fault;
        instr_d = instr_q;
        if (fetch_accept) begin
            instr_d = fetch_fault ? NOP_WORD : mem_q[word_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= ST_LOADING;
            ptr_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Array is deliberately not reset: words survive a reset mid-load.
    always_ff @(posedge Clk_i) begin
        if (load_accept && !Reset_i) begin
            mem_q[ptr_q] <= LoadData_i;
        end
    end

    assign LoadReady_o      = (state_q == ST_LOADING);
    assign Loaded_o         = (state_q == ST_RUN);
    assign FetchStall_o     = FetchReq_i && (state_q != ST_RUN);
    assign InstructionOut_o = instr_q;
    assign FetchValid_o     = valid_q;
    assign FetchFault_o     = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - directed self-checking bench for instr_mem_loadable

module tb_instr_mem_loadable;

    logic        Clk;
    logic        Reset;
    logic        LoadStart;
    logic        LoadValid;
    logic [31:0] LoadData;
    logic        LoadLast;
    logic        LoadReady;
    logic        Loaded;
    logic        FetchReq;
    logic [31:0] Address;
    logic        FetchStall;
    logic [31:0] InstructionOut;
    logic        FetchValid;
    logic        FetchFault;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_mem_loadable #(
        .DEPTH_WORDS(64),
        .ADDR_WIDTH (32),
        .NOP_WORD   (NOP)
    ) dut (
        .Clk_i           (Clk),
        .Reset_i         (Reset),
        .LoadStart_i     (LoadStart),
        .LoadValid_i     (LoadValid),
        .LoadData_i      (LoadData),
        .LoadLast_i      (LoadLast),
        .LoadReady_o     (LoadReady),
        .Loaded_o        (Loaded),
        .FetchReq_i      (FetchReq),
        .Address_i       (Address),
        .FetchStall_o    (FetchStall),
        .InstructionOut_o(InstructionOut),
        .FetchValid_o    (FetchValid),
        .FetchFault_o    (FetchFault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        LoadValid = 1'b1;
        LoadData  = d;
        LoadLast  = last;
        tick();
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        FetchReq = 1'b1;
        Address  = a;
        tick();
        FetchReq = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        total++; if (LoadReady !== 1'b1) begin bad++; $display("FAIL reset_loadready got %b exp 1", LoadReady); end
        total++; if (Loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got %b exp 0", Loaded); end
        total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL reset_fetchvalid got %b exp 0", FetchValid); end
        total++; if (FetchFault !== 1'b0) begin bad++; $display("FAIL reset_fetchfault got %b exp 0", FetchFault); end
        total++; if (InstructionOut !== 32'h0) begin bad++; $display("FAIL reset_instr got %h exp 00000000", InstructionOut); end
    endtask

    task automatic test_load_and_stall();
        logic [31:0] img [4];
        img[0] = 32'h0000_0093; img[1] = 32'h0010_0113;
        img[2] = 32'h0020_81B3; img[3] = 32'h0000_0013;
        FetchReq = 1'b1;
        Address  = 32'h4;
        #1;
        total++; if (FetchStall !== 1'b1) begin bad++; $display("FAIL stall_while_loading got %b exp 1", FetchStall); end
        for (int i = 0; i < 4; i++) begin
            load_word(img[i], i == 3);
            total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL no_valid_while_loading word=%0d got %b exp 0", i, FetchValid); end
            total++; if (Loaded !== (i == 3)) begin bad++; $display("FAIL loaded_after_word word=%0d got %b exp %b", i, Loaded, i == 3); end
            total++; if (LoadReady !== (i != 3)) begin bad++; $display("FAIL loadready_after_word word=%0d got %b exp %b", i, LoadReady, i != 3); end
        end
        total++; if (FetchStall !== 1'b0) begin bad++; $display("FAIL stall_released got %b exp 0", FetchStall); end
        tick();
        FetchReq = 1'b0;
        total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL held_req_valid got %b exp 1", FetchValid); end
        total++; if (InstructionOut !== 32'h0010_0113) begin bad++; $display("FAIL held_req_data got %h exp 00100113", InstructionOut); end
        total++; if (FetchFault !== 1'b0) begin bad++; $display("FAIL held_req_fault got %b exp 0", FetchFault); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] img [4];
        img[0] = 32'h0000_0093; img[1] = 32'h0010_0113;
        img[2] = 32'h0020_81B3; img[3] = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            FetchReq = 1'b1;
            Address  = 32'(i * 4);
            tick();
            total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL b2b_valid idx=%0d got %b exp 1", i, FetchValid); end
            total++; if (InstructionOut !== img[i]) begin bad++; $display("FAIL b2b_data idx=%0d got %h exp %h", i, InstructionOut, img[i]); end
            total++; if (FetchFault !== 1'b0) begin bad++; $display("FAIL b2b_fault idx=%0d got %b exp 0", i, FetchFault); end
        end
        FetchReq = 1'b0;
        Address  = 32'h8;
        tick();
        total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL idle_valid got %b exp 0", FetchValid); end
        total++; if (InstructionOut !== 32'h0000_0013) begin bad++; $display("FAIL idle_hold got %h exp 00000013", InstructionOut); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        addrs[0] = 32'h6; addrs[1] = 32'h100; addrs[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i]);
            total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL fault_valid addr=%h got %b exp 1", addrs[i], FetchValid); end
            total++; if (FetchFault !== 1'b1) begin bad++; $display("FAIL fault_flag addr=%h got %b exp 1", addrs[i], FetchFault); end
            total++; if (InstructionOut !== NOP) begin bad++; $display("FAIL fault_nop addr=%h got %h exp %h", addrs[i], InstructionOut, NOP); end
        end
        fetch(32'h8);
        total++; if (FetchFault !== 1'b0) begin bad++; $display("FAIL fault_cleared got %b exp 0", FetchFault); end
        total++; if (InstructionOut !== 32'h0020_81B3) begin bad++; $display("FAIL after_fault_data got %h exp 002081b3", InstructionOut); end
    endtask

    task automatic test_full_load();
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        total++; if (Loaded !== 1'b0 || LoadReady !== 1'b1) begin bad++; $display("FAIL restart_state got loaded=%b ready=%b exp 0 1", Loaded, LoadReady); end
        for (int i = 0; i < 64; i++) begin
            load_word(32'hA000_0000 + 32'(i), 1'b0);
            if (i == 62) begin
                total++; if (Loaded !== 1'b0) begin bad++; $display("FAIL full_not_done_62 got %b exp 0", Loaded); end
            end
        end
        total++; if (Loaded !== 1'b1) begin bad++; $display("FAIL full_loaded got %b exp 1", Loaded); end
        fetch(32'hFC);
        total++; if (InstructionOut !== 32'hA000_003F) begin bad++; $display("FAIL full_word63 got %h exp a000003f", InstructionOut); end
        load_word(32'h5555_5555, 1'b0);
        total++; if (Loaded !== 1'b1) begin bad++; $display("FAIL run_ignores_load got %b exp 1", Loaded); end
        fetch(32'h0);
        total++; if (InstructionOut !== 32'hA000_0000) begin bad++; $display("FAIL run_mem0_kept got %h exp a0000000", InstructionOut); end
    endtask

    task automatic test_loadstart_with_fetch();
        LoadStart = 1'b1;
        FetchReq  = 1'b1;
        Address   = 32'h0;
        tick();
        LoadStart = 1'b0;
        FetchReq  = 1'b0;
        total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL ls_fetch_valid got %b exp 1", FetchValid); end
        total++; if (InstructionOut !== 32'hA000_0000) begin bad++; $display("FAIL ls_fetch_old got %h exp a0000000", InstructionOut); end
        total++; if (Loaded !== 1'b0) begin bad++; $display("FAIL ls_loaded got %b exp 0", Loaded); end
        load_word(32'hDEAD_BEEF, 1'b1);
        total++; if (Loaded !== 1'b1) begin bad++; $display("FAIL reload_loaded got %b exp 1", Loaded); end
        fetch(32'h0);
        total++; if (InstructionOut !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reload_word0 got %h exp deadbeef", InstructionOut); end
        fetch(32'h4);
        total++; if (InstructionOut !== 32'hA000_0001) begin bad++; $display("FAIL reload_word1_kept got %h exp a0000001", InstructionOut); end
    endtask

    task automatic test_reset_midload();
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        load_word(32'h1111_1111, 1'b0);
        load_word(32'h2222_2222, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total++; if (LoadReady !== 1'b1 || Loaded !== 1'b0) begin bad++; $display("FAIL midreset_state got ready=%b loaded=%b exp 1 0", LoadReady, Loaded); end
        total++; if (InstructionOut !== 32'h0 || FetchValid !== 1'b0 || FetchFault !== 1'b0) begin bad++; $display("FAIL midreset_outputs got instr=%h valid=%b fault=%b exp 0 0 0", InstructionOut, FetchValid, FetchFault); end
        for (int i = 0; i < 4; i++) load_word(32'hC000_0000 + 32'(i), i == 3);
        total++; if (Loaded !== 1'b1) begin bad++; $display("FAIL midreset_reloaded got %b exp 1", Loaded); end
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            total++; if (InstructionOut !== 32'hC000_0000 + 32'(i)) begin bad++; $display("FAIL midreset_data idx=%0d got %h exp %h", i, InstructionOut, 32'hC000_0000 + 32'(i)); end
        end
        fetch(32'h10);
        total++; if (InstructionOut !== 32'hA000_0004) begin bad++; $display("FAIL midreset_word4_kept got %h exp a0000004", InstructionOut); end
    endtask

    initial begin
        Reset     = 1'b1;
        LoadStart = 1'b0;
        LoadValid = 1'b0;
        LoadData  = '0;
        LoadLast  = 1'b0;
        FetchReq  = 1'b0;
        Address   = '0;
        test_reset();
        test_load_and_stall();
        test_back_to_back();
        test_faults();
        test_full_load();
        test_loadstart_with_fetch();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
